// File: rtl/mpt_pkg.sv
// Shared types for the MPT table-memory responder: the response entry that
// travels down the latency pipeline and the decode error classification.
package mpt_pkg;

    // Bus data width the response type is built for. The responder checks at
    // elaboration that its DATA_WIDTH matches.
    localparam int unsigned MPT_DATA_WIDTH = 64;

    typedef struct packed {
        logic                      valid;
        logic                      error;
        logic [MPT_DATA_WIDTH-1:0] rdata;
    } mem_rsp_t;

    typedef enum logic [1:0] {
        MEM_ERR_NONE,
        MEM_ERR_MISALIGNED,
        MEM_ERR_RANGE
    } mem_err_e;

    // Misalignment is reported in preference to range when both apply.
    function automatic mem_err_e classify_err(input logic misaligned,
                                              input logic out_of_range);
        if (misaligned) begin
            return MEM_ERR_MISALIGNED;
        end
        if (out_of_range) begin
            return MEM_ERR_RANGE;
        end
        return MEM_ERR_NONE;
    endfunction

endpackage

// File: rtl/mpt_mem_latency_pipe.sv
// Fixed-length shift register of response entries. The entry pushed at one
// edge appears on 'oldest' STAGES cycles later; flush empties every slot.
module mpt_mem_latency_pipe
    import mpt_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic     clk,
    input  logic     flush,
    input  mem_rsp_t entry,
    output mem_rsp_t oldest
);

    mem_rsp_t stage_q [STAGES];

    // Advance every slot by one each cycle; flush drops all in-flight entries.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let every slot read the previous
        // cycle's neighbour, so the loop shifts instead of collapsing.
        if (flush) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= entry;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign oldest = stage_q[STAGES-1];

endmodule

// File: rtl/mpt_mem_responder.sv
// Memory-slave endpoint for the walker's table-memory port. Accepts req/gnt
// reads and writes against a local word array, and returns in-order
// responses a fixed READ_LATENCY cycles after the grant edge.
module mpt_mem_responder
    import mpt_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH      = MPT_DATA_WIDTH,
    parameter int unsigned           ADDR_WIDTH      = 64,
    parameter int unsigned           DEPTH           = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int unsigned           READ_LATENCY    = 2,
    parameter int unsigned           MAX_OUTSTANDING = 4,
    localparam int unsigned          BE_WIDTH        = DATA_WIDTH / 8,
    localparam int unsigned          IDX_WIDTH       = $clog2(DEPTH),
    localparam int unsigned          CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  memory_slave_mem_req,
    output logic                  memory_slave_mem_gnt,
    input  logic [ADDR_WIDTH-1:0] memory_slave_mem_addr,
    input  logic                  memory_slave_mem_we,
    input  logic [DATA_WIDTH-1:0] memory_slave_mem_wdata,
    input  logic [BE_WIDTH-1:0]   memory_slave_mem_be,
    output logic                  memory_slave_mem_valid,
    output logic [DATA_WIDTH-1:0] memory_slave_mem_rdata,
    output logic                  memory_slave_mem_error,
    input  logic                  gnt_stall_i,
    input  logic                  bd_we_i,
    input  logic [IDX_WIDTH-1:0]  bd_idx_i,
    input  logic [DATA_WIDTH-1:0] bd_wdata_i,
    output logic [CNT_WIDTH-1:0]  outstanding_o
);

    localparam int unsigned OFF_BITS = $clog2(BE_WIDTH);

    // Reject parameter sets the datapath is not built for.
    if (DATA_WIDTH != MPT_DATA_WIDTH) begin : g_bad_data_width
        $error("DATA_WIDTH must equal mpt_pkg::MPT_DATA_WIDTH");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
        $error("READ_LATENCY must be in 1..8");
    end
    if (MAX_OUTSTANDING < 1) begin : g_bad_outstanding
        $error("MAX_OUTSTANDING must be at least 1");
    end

    // ---------------------------------------------------------------- decode
    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] word_off;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  err;
    mem_err_e              err_cause;
    logic [IDX_WIDTH-1:0]  idx;

    // Addresses below BASE_ADDR wrap to huge offsets and land out of range.
    assign off          = memory_slave_mem_addr - BASE_ADDR;
    assign word_off     = off >> OFF_BITS;
    assign misaligned   = off[OFF_BITS-1:0] != '0;
    assign out_of_range = word_off >= ADDR_WIDTH'(DEPTH);
    assign err          = misaligned | out_of_range;
    assign err_cause    = classify_err(misaligned, out_of_range);
    assign idx          = word_off[IDX_WIDTH-1:0];

    // ----------------------------------------------------------------- grant
    mem_rsp_t             entry;
    mem_rsp_t             oldest;
    logic                 delivered;
    logic                 room;
    logic                 gnt;
    logic                 bus_wr;
    logic [CNT_WIDTH-1:0] outstanding_q;

    // The response leaving this cycle frees its slot immediately, so a full
    // responder still grants in the cycle its oldest response is delivered.
    assign delivered = oldest.valid;
    assign room      = (outstanding_q < CNT_WIDTH'(MAX_OUTSTANDING)) | delivered;
    assign gnt       = memory_slave_mem_req & ~gnt_stall_i & ~rst_i & room;
    assign bus_wr    = gnt & memory_slave_mem_we & ~err;

    // ----------------------------------------------------------------- array
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Backdoor word load and byte-masked bus write. The bus assignment comes
    // second, so its bytes win when both target the same word.
    always_ff @(posedge clk_i) begin
        // NOTE: the array is deliberately left out of reset; it is storage,
        // not control, and preloaded contents must survive a reset.
        if (bd_we_i) begin
            mem[bd_idx_i] <= bd_wdata_i;
        end
        if (bus_wr) begin
            for (int b = 0; b < int'(BE_WIDTH); b++) begin
                if (memory_slave_mem_be[b]) begin
                    mem[idx][b*8 +: 8] <= memory_slave_mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Build the response at grant time; a read sees the word as it stands
    // before this edge's writes land.
    always_comb begin
        // NOTE: assigning the default first covers every path, so no latch.
        entry = '0;
        if (gnt) begin
            entry.valid = 1'b1;
            entry.error = err;
            if (!memory_slave_mem_we && !err) begin
                entry.rdata = mem[idx];
            end
        end
    end

    mpt_mem_latency_pipe #(
        .STAGES (READ_LATENCY)
    ) u_pipe (
        .clk    (clk_i),
        .flush  (rst_i),
        .entry  (entry),
        .oldest (oldest)
    );

    // In-flight count: up on grant, down on delivery, steady when both.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
        end else begin
            case ({gnt, delivered})
                2'b10:   outstanding_q <= outstanding_q + CNT_WIDTH'(1);
                2'b01:   outstanding_q <= outstanding_q - CNT_WIDTH'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign memory_slave_mem_gnt   = gnt;
    assign memory_slave_mem_valid = oldest.valid;
    assign memory_slave_mem_error = oldest.error;
    assign memory_slave_mem_rdata = oldest.rdata;
    assign outstanding_o          = outstanding_q;

    // Counter stays within bounds and every delivery has a matching grant.
    a_cnt_bound : assert property (@(posedge clk_i) disable iff (rst_i)
        outstanding_q <= CNT_WIDTH'(MAX_OUTSTANDING));
    a_no_orphan : assert property (@(posedge clk_i) disable iff (rst_i)
        delivered |-> (outstanding_q != '0));
    a_err_cause : assert property (@(posedge clk_i)
        (err_cause != MEM_ERR_NONE) == err);

endmodule

// File: tb/tb_mpt_mem_responder.sv
// Bench for mpt_mem_responder. Instance a uses the default parameters
// (latency 2, four outstanding); instance b uses latency 3 with a single
// outstanding slot. A queue-based model predicts gnt/valid/error/rdata and
// the in-flight count every cycle; directed tests pin literal values.
module tb_mpt_mem_responder;

    localparam int DEPTH = 1024;
    localparam int RL_A  = 2;
    localparam int MO_A  = 4;
    localparam int RL_B  = 3;
    localparam int MO_B  = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req      [2];
    logic        we       [2];
    logic [63:0] addr     [2];
    logic [63:0] wdata    [2];
    logic [7:0]  be       [2];
    logic        stall    [2];
    logic        bd_we    [2];
    logic [9:0]  bd_idx   [2];
    logic [63:0] bd_wdata [2];
    wire         gnt      [2];
    wire         valid    [2];
    wire         err      [2];
    wire  [63:0] rdata    [2];
    wire  [2:0]  outs_a;
    wire  [0:0]  outs_b;

    mpt_mem_responder #(
        .DATA_WIDTH(64), .ADDR_WIDTH(64), .DEPTH(DEPTH), .BASE_ADDR(64'h0),
        .READ_LATENCY(RL_A), .MAX_OUTSTANDING(MO_A)
    ) u_a (
        .clk_i(clk), .rst_i(rst),
        .memory_slave_mem_req(req[0]), .memory_slave_mem_gnt(gnt[0]),
        .memory_slave_mem_addr(addr[0]), .memory_slave_mem_we(we[0]),
        .memory_slave_mem_wdata(wdata[0]), .memory_slave_mem_be(be[0]),
        .memory_slave_mem_valid(valid[0]), .memory_slave_mem_rdata(rdata[0]),
        .memory_slave_mem_error(err[0]), .gnt_stall_i(stall[0]),
        .bd_we_i(bd_we[0]), .bd_idx_i(bd_idx[0]), .bd_wdata_i(bd_wdata[0]),
        .outstanding_o(outs_a)
    );

    mpt_mem_responder #(
        .DATA_WIDTH(64), .ADDR_WIDTH(64), .DEPTH(DEPTH), .BASE_ADDR(64'h0),
        .READ_LATENCY(RL_B), .MAX_OUTSTANDING(MO_B)
    ) u_b (
        .clk_i(clk), .rst_i(rst),
        .memory_slave_mem_req(req[1]), .memory_slave_mem_gnt(gnt[1]),
        .memory_slave_mem_addr(addr[1]), .memory_slave_mem_we(we[1]),
        .memory_slave_mem_wdata(wdata[1]), .memory_slave_mem_be(be[1]),
        .memory_slave_mem_valid(valid[1]), .memory_slave_mem_rdata(rdata[1]),
        .memory_slave_mem_error(err[1]), .gnt_stall_i(stall[1]),
        .bd_we_i(bd_we[1]), .bd_idx_i(bd_idx[1]), .bd_wdata_i(bd_wdata[1]),
        .outstanding_o(outs_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [63:0] pat(input int k);
        return {32'hC0DE_0000 | 32'(k), 32'h5A5A_5A5A ^ 32'(k)};
    endfunction

    function automatic int get_out(input int i);
        return (i == 0) ? int'(outs_a) : int'(outs_b);
    endfunction

    function automatic int rl_of(input int i);
        return (i == 0) ? RL_A : RL_B;
    endfunction

    function automatic int mo_of(input int i);
        return (i == 0) ? MO_A : MO_B;
    endfunction

    // ------------------------------------------------------------------ model
    typedef struct {
        int          due;
        logic        error;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q [2][$];
    logic [63:0] mm    [2][DEPTH];
    int          vcyc  [2][$];
    logic [63:0] vdat  [2][$];
    int          peak  [2];
    int          cyc = 0;
    logic        model_on;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare this cycle's outputs against the model, then advance the model
    // to the state after the coming edge.
    task automatic model_step(input int i);
        logic        due_now;
        logic        exp_gnt;
        logic        bad;
        logic [63:0] off;
        logic [63:0] word;
        int          n_left;
        exp_t        e;
        due_now = (exp_q[i].size() > 0) && (exp_q[i][0].due == cyc);
        n_left  = exp_q[i].size() - (due_now ? 1 : 0);
        exp_gnt = req[i] && !stall[i] && !rst && (n_left < mo_of(i));
        check($sformatf("i%0d gnt c%0d", i, cyc), 64'(gnt[i]), 64'(exp_gnt));
        check($sformatf("i%0d valid c%0d", i, cyc), 64'(valid[i]), 64'(due_now));
        check($sformatf("i%0d outstanding c%0d", i, cyc), 64'(get_out(i)), 64'(exp_q[i].size()));
        if (due_now) begin
            check($sformatf("i%0d error c%0d", i, cyc), 64'(err[i]), 64'(exp_q[i][0].error));
            check($sformatf("i%0d rdata c%0d", i, cyc), rdata[i], exp_q[i][0].data);
        end
        if (valid[i] === 1'b1) begin
            vcyc[i].push_back(cyc);
            vdat[i].push_back(rdata[i]);
        end
        if (get_out(i) > peak[i]) peak[i] = get_out(i);

        off  = addr[i] - 64'h0;
        word = off / 8;
        bad  = (off % 8 != 0) || (word >= 64'(DEPTH));
        if (rst) begin
            exp_q[i].delete();
        end else begin
            if (due_now) void'(exp_q[i].pop_front());
            if (exp_gnt) begin
                e.due   = cyc + rl_of(i);
                e.error = bad;
                e.data  = (bad || we[i]) ? 64'h0 : mm[i][int'(word)];
                exp_q[i].push_back(e);
            end
        end
        if (bd_we[i]) mm[i][bd_idx[i]] = bd_wdata[i];
        if (exp_gnt && we[i] && !bad) begin
            for (int b = 0; b < 8; b++) begin
                if (be[i][b]) mm[i][int'(word)][8*b +: 8] = wdata[i][8*b +: 8];
            end
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic issue(input int i, input logic w, input logic [63:0] a,
                         input logic [63:0] d, input logic [7:0] b, output int gc);
        int tries;
        tries = 0;
        gc    = -1;
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
        while (gc < 0 && tries < 40) begin
            @(negedge clk);
            if (gnt[i] === 1'b1) gc = cyc;
            tries++;
            @(posedge clk);
            #1;
        end
        req[i] = 1'b0;
        we[i]  = 1'b0;
        if (gc < 0) check("gnt timeout", 64'(gnt[i]), 64'd1);
    endtask

    task automatic at_neg(input int target);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (cyc < target && guard < 1000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g [8];
        int c0, gw, gr, ge1, ge2, gx, ga, gb, gy;
        model_on = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; be[i] = '0;
            stall[i] = 1'b0; bd_we[i] = 1'b0; bd_idx[i] = '0; bd_wdata[i] = '0;
            peak[i] = 0;
        end
        req[0] = 1'b1;  // request during reset must not be granted
        @(posedge clk); #1;
        model_on = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        req[0] = 1'b0;
        @(negedge clk);
        check("reset outstanding", 64'(get_out(0)), 64'd0);
        check("reset valid", 64'(valid[0]), 64'd0);
        @(posedge clk); #1;

        // Backdoor preload; instance a gets the test word at idx 3.
        for (int k = 0; k < DEPTH; k++) begin
            for (int i = 0; i < 2; i++) begin
                bd_we[i]    = 1'b1;
                bd_idx[i]   = 10'(k);
                bd_wdata[i] = (i == 0 && k == 3) ? 64'hDEAD_BEEF_0123_4567 : pat(k);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 2; i++) bd_we[i] = 1'b0;

        // Plain read of idx 3.
        c0 = cyc;
        issue(0, 1'b0, 64'h18, 64'h0, 8'hFF, gr);
        check("t1 gnt same cycle", 64'(gr - c0), 64'd0);
        at_neg(gr + 1);
        check("t1 no early valid", 64'(valid[0]), 64'd0);
        at_neg(gr + 2);
        check("t1 valid", 64'(valid[0]), 64'd1);
        check("t1 error", 64'(err[0]), 64'd0);
        check("t1 rdata", rdata[0], 64'hDEAD_BEEF_0123_4567);

        // Byte-masked write then immediate read-back.
        issue(0, 1'b1, 64'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, gw);
        issue(0, 1'b0, 64'h18, 64'h0, 8'hFF, gr);
        check("t2 back-to-back gnt", 64'(gr - gw), 64'd1);
        at_neg(gr + 2);
        check("t2 rdata", rdata[0], 64'hDEAD_BEEF_FFFF_FFFF);

        // Misaligned and out-of-range reads, then errored writes.
        issue(0, 1'b0, 64'h1C, 64'h0, 8'hFF, ge1);
        issue(0, 1'b0, 64'h2000, 64'h0, 8'hFF, ge2);
        at_neg(ge1 + 2);
        check("t3 misaligned error", 64'(err[0]), 64'd1);
        check("t3 misaligned rdata", rdata[0], 64'h0);
        at_neg(ge2 + 2);
        check("t3 range valid", 64'(valid[0]), 64'd1);
        check("t3 range error", 64'(err[0]), 64'd1);
        check("t3 range rdata", rdata[0], 64'h0);
        @(posedge clk); #1;
        issue(0, 1'b1, 64'h1C, 64'h0, 8'hFF, ge1);
        issue(0, 1'b1, 64'h2000, 64'h0, 8'hFF, ge2);
        issue(0, 1'b0, 64'h18, 64'h0, 8'hFF, gr);
        issue(0, 1'b0, 64'h0, 64'h0, 8'hFF, gy);
        at_neg(gr + 2);
        check("t3 idx3 unchanged", rdata[0], 64'hDEAD_BEEF_FFFF_FFFF);
        at_neg(gy + 2);
        check("t3 idx0 unchanged", rdata[0], pat(0));

        // Stall hook holds gnt low.
        @(posedge clk); #1;
        stall[0] = 1'b1; req[0] = 1'b1; addr[0] = 64'h8; we[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall gnt", 64'(gnt[0]), 64'd0);
        end
        @(posedge clk); #1;
        stall[0] = 1'b0; req[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Instance b: one outstanding, latency 3, request held.
        vcyc[1].delete(); vdat[1].delete(); peak[1] = 0;
        for (int k = 0; k < 4; k++) issue(1, 1'b0, 64'(k * 8), 64'h0, 8'hFF, g[k]);
        at_neg(g[3] + 4);
        for (int k = 1; k < 4; k++) check($sformatf("t4 gnt spacing %0d", k), 64'(g[k] - g[k-1]), 64'd3);
        check("t4 peak outstanding", 64'(peak[1]), 64'd1);
        check("t4 response count", 64'(vcyc[1].size()), 64'd4);
        for (int k = 0; k < 4 && k < vcyc[1].size(); k++) begin
            check($sformatf("t4 resp cycle %0d", k), 64'(vcyc[1][k] - g[k]), 64'd3);
            check($sformatf("t4 resp data %0d", k), vdat[1][k], pat(k));
        end

        // Instance a: eight back-to-back reads.
        @(posedge clk); #1;
        vcyc[0].delete(); vdat[0].delete(); peak[0] = 0;
        for (int k = 0; k < 8; k++) issue(0, 1'b0, 64'(k * 8), 64'h0, 8'hFF, g[k]);
        at_neg(g[7] + 3);
        check("t5 grant run", 64'(g[7] - g[0]), 64'd7);
        check("t5 response count", 64'(vcyc[0].size()), 64'd8);
        for (int k = 0; k < 8 && k < vcyc[0].size(); k++) begin
            check($sformatf("t5 resp cycle %0d", k), 64'(vcyc[0][k] - g[0]), 64'(k + 2));
            check($sformatf("t5 resp data %0d", k), vdat[0][k],
                  (k == 3) ? 64'hDEAD_BEEF_FFFF_FFFF : pat(k));
        end
        check("t5 peak outstanding", 64'(peak[0]), 64'd2);

        // Reset with two reads in flight.
        @(posedge clk); #1;
        issue(0, 1'b0, 64'h28, 64'h0, 8'hFF, ga);
        issue(0, 1'b0, 64'h30, 64'h0, 8'hFF, gb);
        rst = 1'b1;
        @(negedge clk);
        check("t6 in flight before reset", 64'(get_out(0)), 64'd2);
        @(posedge clk); #1;
        rst = 1'b0;
        vcyc[0].delete(); vdat[0].delete();
        repeat (6) @(negedge clk);
        check("t6 no valid after reset", 64'(vcyc[0].size()), 64'd0);
        check("t6 outstanding after reset", 64'(get_out(0)), 64'd0);
        @(posedge clk); #1;
        issue(0, 1'b0, 64'h18, 64'h0, 8'hFF, gx);
        issue(0, 1'b0, 64'h28, 64'h0, 8'hFF, gy);
        at_neg(gx + 2);
        check("t6 idx3 preserved", rdata[0], 64'hDEAD_BEEF_FFFF_FFFF);
        at_neg(gy + 2);
        check("t6 idx5 preserved", rdata[0], pat(5));

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mpt_mem_responder.md
Name: mpt_mem_responder

Overview:
- Memory-slave endpoint for the walking-stage memory master port: accepts req/gnt read and write transactions and returns in-order responses (valid/rdata/error) after a fixed latency.
- Backed by a local word array that holds MPT table contents, preloaded through a backdoor port.
- Used as the table-memory model in walker benches, and as an on-chip table SRAM wrapper in integration.

Parameters:
- DATA_WIDTH, 64, bus data width in bits; power of two, >= 32.
- ADDR_WIDTH, 64, bus address width in bits.
- DEPTH, 1024, number of DATA_WIDTH words in the array.
- BASE_ADDR, 64'h0, byte address of word 0; aligned to DATA_WIDTH/8.
- READ_LATENCY, 2, cycles from grant to response valid; legal range 1..8.
- MAX_OUTSTANDING, 4, maximum granted but unresponded requests; must be >= 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- memory_slave_mem_req  in  1  request valid.
- memory_slave_mem_gnt  out  1  request accepted this cycle.
- memory_slave_mem_addr  in  ADDR_WIDTH  byte address.
- memory_slave_mem_we  in  1  1 = write, 0 = read.
- memory_slave_mem_wdata  in  DATA_WIDTH  write data.
- memory_slave_mem_be  in  DATA_WIDTH/8  byte enables.
- memory_slave_mem_valid  out  1  response valid; no ready, master must sink it.
- memory_slave_mem_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- memory_slave_mem_error  out  1  response is an error; qualified by valid.
- gnt_stall_i  in  1  test hook; forces gnt low while high.
- bd_we_i  in  1  backdoor word write.
- bd_idx_i  in  $clog2(DEPTH)  backdoor word index.
- bd_wdata_i  in  DATA_WIDTH  backdoor data.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current in-flight count.

Behaviour:
- Reset (rst_i high at clk edge):
  - gnt, valid, error, rdata, outstanding_o = 0; latency pipeline flushed.
  - Array contents are not reset.
  - In-flight responses are dropped silently; the master resets with the same reset.
- Grant (combinational):
  - gnt = req & ~gnt_stall_i & ~rst_i & (outstanding < MAX_OUTSTANDING).
  - The request is accepted at the edge where req & gnt.
  - Address, we, wdata and be are sampled only in the grant cycle.
- Decode:
  - off = addr - BASE_ADDR, ADDR_WIDTH unsigned wrap.
  - Misaligned: off[$clog2(DATA_WIDTH/8)-1:0] != 0.
  - Out of range: (off >> $clog2(DATA_WIDTH/8)) >= DEPTH, also true when addr < BASE_ADDR because of the wrap.
  - err = misaligned | out of range.
- Write, granted and err=0: bytes with be[i]=1 update at the grant edge; other bytes unchanged. be=0 is a legal no-op that still responds.
- Read, granted: the array word is captured at the grant edge. A write granted at cycle N is visible to a read granted at N+1.
- Errors: no array update; the response carries error=1 and rdata=0.
- Backdoor:
  - bd_we_i writes the full word at the edge.
  - A same-cycle backdoor write and bus write to the same index: the bus write wins.
  - A bus read granted in the same cycle as a backdoor write to its word returns the old data.
- Response pipeline: the entry {valid, error, rdata} shifts through READ_LATENCY registers. valid rises exactly READ_LATENCY cycles after the grant edge, one response per cycle, in grant order. Back-to-back grants give back-to-back responses.
- Outstanding counter:
  - +1 on grant, -1 on response valid; unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING and never underflows.
  - When MAX_OUTSTANDING < READ_LATENCY, gnt drops once the counter saturates and reasserts in the cycle the oldest response is delivered (that response's -1 is counted combinationally).

Decomposition:
- mpt_pkg holds the shared response typedef mem_rsp_t {valid, error, rdata} and the error-cause enum mem_err_e {MEM_ERR_NONE, MEM_ERR_MISALIGNED, MEM_ERR_RANGE}. The cause is exposed internally only, for assertions.
- One sub-module: mpt_mem_latency_pipe, a parameterised shift register of mem_rsp_t with a synchronous flush.
- The array and decode stay in the top module.

Test Plan:
- Backdoor-load idx 3 = 64'hDEAD_BEEF_0123_4567, BASE_ADDR = 0, read addr 0x18 -> gnt same cycle, valid 2 cycles later, rdata = 64'hDEAD_BEEF_0123_4567, error = 0.
- Write addr 0x18, wdata all 0xFF, be = 8'h0F, then read 0x18 the next cycle -> rdata = 64'hDEAD_BEEF_FFFF_FFFF.
- Read addr 0x1C (misaligned) and addr 0x2000 (DEPTH = 1024, out of range) -> each responds valid with error = 1, rdata = 0; the array is unchanged.
- MAX_OUTSTANDING = 1, READ_LATENCY = 3, req held high with 4 reads -> one gnt every 3 cycles; outstanding_o never exceeds 1; responses arrive in order.
- READ_LATENCY = 2, 8 consecutive reads to idx 0..7 -> 8 consecutive valid cycles in order; outstanding_o peaks at 2.
- Assert rst_i with 2 reads in flight -> no valid after reset; outstanding_o = 0; backdoor contents preserved on the next read.
